// File: rtl/sram_if_pkg.sv
// Package: sram_if_pkg
//   Shared definitions for the sram-like data-memory responder: FSM state
//   encodings, access size codes and the wait-state counter width.
package sram_if_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int CNT_W = 4;

endpackage

// File: rtl/sram_strobe_gen.sv
// Module: sram_strobe_gen
//   Combinational byte-lane strobe decode for the sram-like responder.
// Ports:
//   size     in  2  access size (0 byte, 1 half, 2 word, 3 reserved = word)
//   addr_lo  in  2  low byte-address bits
//   wr       in  1  1 = write; strobes are forced to zero for reads
//   wen      out 4  SRAM byte write enables
//   misalign out 1  half access with addr[0] set, or word access with addr[1:0] nonzero
module sram_strobe_gen
  import sram_if_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  input  logic       wr,
  output logic [3:0] wen,
  output logic       misalign
);

  logic [3:0] strb;

  always_comb begin
    strb     = 4'b1111;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: strb = 4'b0001 << addr_lo;
      SZ_HALF: begin
        // addr[0] is ignored for lane selection; it only feeds the misalign flag.
        strb     = 4'b0011 << {addr_lo[1], 1'b0};
        misalign = addr_lo[0];
      end
      default: begin
        // Word and the reserved code both cover all four lanes.
        strb     = 4'b1111;
        misalign = |addr_lo;
      end
    endcase
    wen = wr ? strb : 4'b0000;
  end

endmodule

// File: rtl/sram_like_resp.sv
// Module: sram_like_resp
//   Responder end of the CPU sram-like data-memory interface (req/addr_ok/data_ok).
//   Accepts one request at a time, optionally stalls WAIT_CYCLES cycles, strobes a
//   synchronous single-port SRAM (1-cycle read latency) for one cycle, then returns
//   a one-cycle data_ok pulse. A new request may be accepted in the response cycle.
// Configuration macro:
//   SRAM_RESP_MISALIGN_CHK_EN - adds output err; misaligned half/word accesses
//   raise err with data_ok, writes are suppressed and reads return zero.
// Ports:
//   clk, resetn            clock (posedge) and asynchronous active-low reset
//   req, wr, size, addr, wdata   request from the MEM stage
//   addr_ok                request accepted when req & addr_ok
//   data_ok, rdata         completion pulse and read word (zero when data_ok=0)
//   ram_en, ram_wen, ram_addr, ram_wdata   SRAM strobe, lanes, word address, data
//   ram_rdata              SRAM read data, valid the cycle after ram_en
//   err                    misalignment flag (only with SRAM_RESP_MISALIGN_CHK_EN)
module sram_like_resp
  import sram_if_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [31:0]       rdata,
  output logic              ram_en,
  output logic [3:0]        ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
`ifdef SRAM_RESP_MISALIGN_CHK_EN
  ,
  output logic              err
`endif
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);
  localparam state_t S_FIRST = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;

  state_t            state, state_nxt;
  logic              accept;
  logic              lat_wr;
  logic [1:0]        lat_size;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        strb_wen;
  logic              misalign;
  logic [ADDR_W-1:0] src_addr;
  logic [31:0]       src_wdata;

  sram_strobe_gen u_strobe (
    .size     (lat_size),
    .addr_lo  (lat_addr[1:0]),
    .wr       (lat_wr),
    .wen      (strb_wen),
    .misalign (misalign)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    ram_en    = 1'b0;
    accept    = 1'b0;
    case (state)
      S_IDLE: begin
        addr_ok = 1'b1;
        if (req) begin
          accept    = 1'b1;
          state_nxt = S_FIRST;
        end
      end
      S_WAIT: begin
        if (cnt <= 4'd1) state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        ram_en    = 1'b1;
        state_nxt = S_RESP;
      end
      default: begin
        addr_ok = 1'b1;
        data_ok = 1'b1;
        if (req) begin
          accept    = 1'b1;
          state_nxt = S_FIRST;
        end else begin
          state_nxt = S_IDLE;
        end
      end
    endcase
  end

`ifdef SRAM_RESP_MISALIGN_CHK_EN
  assign ram_wen = (ram_en && !misalign) ? strb_wen : 4'b0000;
  assign rdata   = (data_ok && !misalign) ? ram_rdata : 32'h0;
  assign err     = data_ok & misalign;
`else
  logic misalign_unused;
  assign misalign_unused = misalign;
  assign ram_wen = ram_en ? strb_wen : 4'b0000;
  assign rdata   = data_ok ? ram_rdata : 32'h0;
`endif

  // Request latch and wait counter
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat_wr    <= 1'b0;
      lat_size  <= 2'd0;
      lat_addr  <= '0;
      lat_wdata <= 32'h0;
      cnt       <= '0;
    end else if (accept) begin
      lat_wr    <= wr;
      lat_size  <= size;
      lat_addr  <= addr;
      lat_wdata <= wdata;
      cnt       <= WAIT_INIT;
    end else if (state == S_WAIT) begin
      cnt <= cnt - 4'd1;
    end
  end

  // With no wait states ACCESS follows the accept directly, so the SRAM address
  // must come from the live request rather than the latch being written.
  assign src_addr  = accept ? addr  : lat_addr;
  assign src_wdata = accept ? wdata : lat_wdata;

  // SRAM address/data are loaded only on entry to ACCESS so they hold otherwise
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ram_addr  <= '0;
      ram_wdata <= 32'h0;
    end else if (state_nxt == S_ACCESS) begin
      ram_addr  <= {src_addr[ADDR_W-1:2], 2'b00};
      ram_wdata <= src_wdata;
    end
  end

endmodule
